// File: rtl/sram_burst_reader_pkg.sv
// ============================================================================
// sram_burst_reader_pkg : shared widths and FSM encoding for the burst reader
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_burst_reader_pkg;

    localparam int C_AW    = 26;
    localparam int C_DW    = 32;
    localparam int C_LW    = 16;
    localparam int C_DEPTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sram_burst_reader_fifo.sv
// ============================================================================
// sram_burst_reader_fifo : synchronous return FIFO with occupancy count
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_burst_reader_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so push into a full FIFO is legal then.
    assign w_push = push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/sram_burst_reader.sv
// ============================================================================
// sram_burst_reader : turns (base,len) commands into single-word SRAM reads
//                     and streams the returned words through a credit FIFO
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_burst_reader
    import sram_burst_reader_pkg::*;
#(
    parameter int AW    = C_AW,
    parameter int DW    = C_DW,
    parameter int LW    = C_LW,
    parameter int DEPTH = C_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    output logic          rvalid,
    input  logic          rready,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_remaining;
    logic          r_inflight;
    logic          r_done;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_used;
    logic          w_empty;
    logic          w_credit;
    logic          w_accept;
    logic          w_cmd_acc;
    logic          w_pop;
    logic          w_last_pop;

    assign w_accept  = rvalid & rready;
    assign w_cmd_acc = cmd_valid & cmd_ready;
    assign w_pop     = out_valid & out_ready;
    // Slots already spoken for: words sitting in the FIFO plus the one still on the bus.
    assign w_used    = w_count + {{(CW-1){1'b0}}, r_inflight};
    assign w_credit  = (w_used < CW'(DEPTH));
    assign w_last_pop = (r_state == S_DRAIN) && w_pop && !r_inflight
                        && (w_count == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_acc && (cmd_len != '0)) w_next = S_ISSUE;
            S_ISSUE: if (w_accept && (r_remaining == LW'(1))) w_next = S_DRAIN;
            S_DRAIN: if (w_last_pop) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        rvalid    = (r_state == S_ISSUE) && (r_remaining != '0) && w_credit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            r_done     <= w_last_pop || (w_cmd_acc && (cmd_len == '0));
            if (w_cmd_acc) begin
                r_addr      <= cmd_addr;
                r_remaining <= cmd_len;
            end else if (w_accept) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    sram_burst_reader_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_inflight),
        .push_data (rdata),
        .pop       (w_pop),
        .pop_data  (out_data),
        .count     (w_count),
        .empty     (w_empty)
    );

    assign raddr     = r_addr;
    assign out_valid = ~w_empty;
    assign busy      = (r_state != S_IDLE) | ~w_empty;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sram_burst_reader.sv
// ============================================================================
// tb_sram_burst_reader : randomized bench with a transaction-level reference
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_burst_reader;

    localparam int AW    = 26;
    localparam int DW    = 32;
    localparam int LW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    sram_burst_reader #(.AW(AW), .DW(DW), .LW(LW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .rvalid    (rvalid),
        .rready    (rready),
        .raddr     (raddr),
        .rdata     (rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // SRAM contents: injective in the address, so any reorder or duplicate shows up.
    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'hA5C3, a[25:10] ^ 16'h3C5A};
    endfunction

    // Reference model: words owed to the sink, words still to request, and
    // requests whose data has not yet left the stream.
    logic [DW-1:0] exp_q[$];
    int            to_issue = 0;
    int            pending = 0;
    int            outstanding = 0;
    logic [AW-1:0] next_addr = '0;
    bit            acc_now = 1'b0;
    bit            last_acc = 1'b0;
    bit            done_next = 1'b0;
    logic [AW-1:0] acc_addr_now = '0;
    int            done_cnt = 0;
    int            pop_cnt = 0;
    int            cyc = 0;
    logic [AW-1:0] log_addr[$];
    int            log_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("rst_cmd_ready", cmd_ready, 1);
            check("rst_rvalid", rvalid, 0);
            check("rst_raddr", raddr, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            exp_q.delete();
            to_issue = 0; pending = 0; outstanding = 0;
            acc_now = 1'b0; last_acc = 1'b0; done_next = 1'b0;
        end else begin
            last_acc = acc_now;
            acc_now  = 1'b0;
            check("done", done, done_next);
            if (done) done_cnt++;
            done_next = 1'b0;
            check("cmd_ready", cmd_ready, pending == 0);
            check("busy", busy, pending > 0);
            check("rvalid", rvalid, (to_issue > 0) && (outstanding < DEPTH));
            check("out_valid", out_valid, (outstanding - int'(last_acc)) > 0);
            if (rvalid) check("raddr", raddr, next_addr);

            if (cmd_valid && cmd_ready) begin
                if (cmd_len == '0) begin
                    done_next = 1'b1;
                end else begin
                    to_issue  = int'(cmd_len);
                    pending   = int'(cmd_len);
                    next_addr = cmd_addr;
                    for (int i = 0; i < int'(cmd_len); i++)
                        exp_q.push_back(memf(cmd_addr + AW'(i)));
                end
            end
            if (rvalid && rready) begin
                acc_now      = 1'b1;
                acc_addr_now = raddr;
                log_addr.push_back(raddr);
                log_cyc.push_back(cyc);
                next_addr = next_addr + 1'b1;
                to_issue--;
                outstanding++;
            end
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word got=%0h exp=none at %0t", out_data, $time);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                    outstanding--;
                    pending--;
                    if (pending == 0) done_next = 1'b1;
                end
            end
        end
    end

    // SRAM responder: accepted data one cycle later, garbage otherwise.
    always @(posedge clk) begin
        #1;
        rdata = acc_now ? memf(acc_addr_now) : DW'($urandom);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_cyc.delete();
        done_cnt = 0;
        pop_cnt  = 0;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int t = 0;
        while (!cmd_ready && t < 300) begin
            tick();
            t++;
        end
        if (t >= 300) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout got=0 exp=1 at %0t", $time);
        end
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, input bit rnd);
        int t = 0;
        while ((pending != 0 || busy) && t < max) begin
            if (rnd) begin
                rready    = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end
            tick();
            t++;
        end
        if (t >= max) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got=busy exp=idle at %0t", $time);
        end
        rready    = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Basic 4-word burst at full rate.
        rready = 1'b1; out_ready = 1'b1;
        clear_logs();
        send(26'h100, 16'd4);
        wait_idle(200, 1'b0);
        check("t1_nreq", log_addr.size(), 4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            check("t1_addr", log_addr[i], 26'h100 + 26'(i));
            check("t1_backtoback", log_cyc[i], log_cyc[0] + i);
        end
        check("t1_words", pop_cnt, 4);
        check("t1_done", done_cnt, 1);
        check("t1_busy", busy, 0);

        // Zero-length command.
        clear_logs();
        send(26'h155, 16'd0);
        tick(); tick(); tick();
        check("t2_nreq", log_addr.size(), 0);
        check("t2_done", done_cnt, 1);

        // Sink stalled: credits cap the requests at DEPTH.
        clear_logs();
        out_ready = 1'b0;
        send(26'h400, 16'd20);
        repeat (30) tick();
        check("t3_nreq_stalled", log_addr.size(), DEPTH);
        check("t3_rvalid_low", rvalid, 0);
        check("t3_words_stalled", pop_cnt, 0);
        out_ready = 1'b1;
        wait_idle(300, 1'b0);
        check("t3_nreq", log_addr.size(), 20);
        check("t3_words", pop_cnt, 20);
        check("t3_done", done_cnt, 1);

        // Random rready / out_ready.
        clear_logs();
        send(26'h2A0, 16'd10);
        wait_idle(2000, 1'b1);
        check("t4_words", pop_cnt, 10);
        check("t4_done", done_cnt, 1);

        // Address wrap.
        clear_logs();
        send(26'h3FFFFFE, 16'd4);
        wait_idle(200, 1'b0);
        check("t5_nreq", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            check("t5_a0", log_addr[0], 26'h3FFFFFE);
            check("t5_a1", log_addr[1], 26'h3FFFFFF);
            check("t5_a2", log_addr[2], 26'h0000000);
            check("t5_a3", log_addr[3], 26'h0000001);
        end

        // Reset mid-burst, then a fresh command.
        clear_logs();
        send(26'h800, 16'd8);
        begin
            int t = 0;
            while (pop_cnt < 3 && t < 100) begin
                tick();
                t++;
            end
            if (t >= 100) begin
                checks++;
                errors++;
                $display("FAIL t6_pop_timeout got=%0d exp=3 at %0t", pop_cnt, $time);
            end
        end
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        check("t6_no_done", done_cnt, 0);
        clear_logs();
        send(26'h200, 16'd2);
        wait_idle(200, 1'b0);
        check("t6_nreq", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("t6_a0", log_addr[0], 26'h200);
            check("t6_a1", log_addr[1], 26'h201);
        end
        check("t6_words", pop_cnt, 2);
        check("t6_done", done_cnt, 1);

        // Random commands under random back-pressure.
        for (int k = 0; k < 6; k++) begin
            logic [AW-1:0] a;
            int            l;
            a = AW'($urandom);
            l = $urandom_range(1, 24);
            clear_logs();
            send(a, LW'(l));
            wait_idle(3000, 1'b1);
            check("rand_words", pop_cnt, l);
            check("rand_done", done_cnt, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
